// File: rtl/conv_load_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_load_sched_pkg
// Shared definitions for the conv_unit layer load sequencer:
//   - default widths for the stream, the para word and the per-layer counters
//   - sequencer state encoding
//   - bit offsets of the weight / feature-map word counts in the descriptor
//   - indices of the two beat counters (weights, feature map)
// -----------------------------------------------------------------------------
package conv_load_sched_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int B_PARA_DEF     = 64;
  localparam int B_CNT_DEF      = 32;

  // Descriptor word: {wei_words[63:32], ftm_words[31:0]}
  localparam int WCNT_LSB = 32;
  localparam int FCNT_LSB = 0;

  // Counter slots inside the sequencer
  localparam int CNT_WEI = 0;
  localparam int CNT_FTM = 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CNT  = 3'd1;
  localparam logic [2:0] ST_CLR  = 3'd2;
  localparam logic [2:0] ST_WEI  = 3'd3;
  localparam logic [2:0] ST_FTM  = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CNT  = ST_CNT,
    S_CLR  = ST_CLR,
    S_WEI  = ST_WEI,
    S_FTM  = ST_FTM,
    S_WAIT = ST_WAIT
  } state_t;

endpackage

// File: rtl/conv_load_sched_if.sv
// -----------------------------------------------------------------------------
// conv_load_sched_if
// Valid/ready read stream from the DDR reader into the layer sequencer.
//   s_tdata   DW bits  stream word
//   s_tvalid  1        word valid (driven by the reader)
//   s_tready  1        word accepted when high together with s_tvalid
// Modports:
//   master : DDR reader side (drives data/valid, observes ready)
//   slave  : sequencer side  (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface conv_load_sched_if #(
  parameter int DW = conv_load_sched_pkg::DATA_WIDTH_DEF
);
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );
endinterface

// File: rtl/conv_load_sched_ld_word_counter.sv
// -----------------------------------------------------------------------------
// ld_word_counter
// Loadable down-counter for the remaining beats of one stream segment.
//   clk, rst   clock, asynchronous active-high reset (count -> 0)
//   load       load load_val (has priority over dec)
//   load_val   W bits, new count
//   dec        consume one beat; ignored once the count is already zero
//   zero       count == 0
//   last       count == 1 (the beat being consumed now is the final one)
// -----------------------------------------------------------------------------
module ld_word_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && !zero) begin
      // Gated by !zero so a stray decrement can never wrap the count
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == W'(1));

endmodule

// File: rtl/conv_load_sched.sv
// -----------------------------------------------------------------------------
// conv_load_sched
// Layer-level sequencer in front of conv_unit. Splits one DDR read stream into
// the layer para word, the descriptor (weight/feature-map word counts), the
// weight words and the feature-map words, and steers them to conv_unit.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   s                stream slave (s_tdata / s_tvalid / s_tready)
//   para, para_we    layer parameter word and its 1-cycle write strobe
//   di               buffer write data (the stream word, combinational)
//   wb_we, fb_we     weight / feature-map buffer write enables (zero latency)
//   wb_clr, fb_clr   1-cycle buffer clears at layer start
//   wb_full, fb_full buffer back-pressure
//   wb_sufficient,
//   fb_sufficient    buffers hold enough data to begin computing
//   cmp_done         compute finished the layer (pulse)
//   start            1-cycle compute start, once per layer
//   busy             high from para accept to layer end
//   layer_done       1-cycle pulse at layer end
// -----------------------------------------------------------------------------
module conv_load_sched
  import conv_load_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int B_PARA     = B_PARA_DEF,
  parameter int B_CNT      = B_CNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_load_sched_if.slave      s,
  output logic [B_PARA-1:0]     para,
  output logic                  para_we,
  output logic [DATA_WIDTH-1:0] di,
  output logic                  fb_we,
  output logic                  wb_we,
  output logic                  fb_clr,
  output logic                  wb_clr,
  input  logic                  fb_full,
  input  logic                  wb_full,
  input  logic                  fb_sufficient,
  input  logic                  wb_sufficient,
  input  logic                  cmp_done,
  output logic                  start,
  output logic                  busy,
  output logic                  layer_done
);

  state_t state_reg;
  state_t state_next;

  logic              rdy;
  logic              beat;
  logic              cnt_load;
  logic [1:0]        cnt_dec;
  logic [1:0]        cnt_zero;
  logic [1:0]        cnt_last;
  logic [B_CNT-1:0]  cnt_init [2];

  logic [B_PARA-1:0] para_reg;
  logic              para_we_reg;
  logic              busy_reg;
  logic              layer_done_reg;
  logic              start_sent_reg;
  logic              done_pend_reg;
  logic              start_c;
  logic              done_ok;

  // ---------------------------------------------------------------------------
  // Weight / feature-map beat counters, loaded together from the descriptor
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam int LSB = (gi == CNT_WEI) ? WCNT_LSB : FCNT_LSB;

    assign cnt_init[gi] = s.s_tdata[LSB +: B_CNT];

    ld_word_counter #(
      .W(B_CNT)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_init[gi]),
      .dec      (cnt_dec[gi]),
      .zero     (cnt_zero[gi]),
      .last     (cnt_last[gi])
    );
  end

  // A compute completion only counts once this layer's start has gone out;
  // an earlier one latched during loading is honoured on reaching WAIT.
  assign done_ok = (cmp_done && start_sent_reg) || done_pend_reg;

  assign start_c = ((state_reg == S_FTM) || (state_reg == S_WAIT)) &&
                   wb_sufficient && fb_sufficient && !start_sent_reg;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and per-beat outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rdy        = 1'b0;
    beat       = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = '0;
    wb_we      = 1'b0;
    fb_we      = 1'b0;

    // Ready depends only on state and the full flags, so a full flag rising
    // withdraws ready in the same cycle and the offered beat simply waits.
    // While reset is held the sequencer accepts nothing.
    case (state_reg)
      S_IDLE,
      S_CNT:   rdy = !rst;
      S_WEI:   rdy = !wb_full;
      S_FTM:   rdy = !fb_full;
      default: rdy = 1'b0;
    endcase

    beat = s.s_tvalid && rdy;

    case (state_reg)
      S_IDLE: begin
        if (beat) state_next = S_CNT;
      end
      S_CNT: begin
        if (beat) begin
          cnt_load   = 1'b1;
          state_next = S_CLR;
        end
      end
      S_CLR: begin
        // One bubble so the clears never overlap a buffer write
        if (!cnt_zero[CNT_WEI])      state_next = S_WEI;
        else if (!cnt_zero[CNT_FTM]) state_next = S_FTM;
        else                         state_next = S_WAIT;
      end
      S_WEI: begin
        if (beat) begin
          wb_we            = 1'b1;
          cnt_dec[CNT_WEI] = 1'b1;
          if (cnt_last[CNT_WEI]) begin
            state_next = cnt_zero[CNT_FTM] ? S_WAIT : S_FTM;
          end
        end
      end
      S_FTM: begin
        if (beat) begin
          fb_we            = 1'b1;
          cnt_dec[CNT_FTM] = 1'b1;
          if (cnt_last[CNT_FTM]) state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_ok) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered layer-level outputs and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      para_reg       <= '0;
      para_we_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      layer_done_reg <= 1'b0;
      start_sent_reg <= 1'b0;
      done_pend_reg  <= 1'b0;
    end else begin
      para_we_reg    <= 1'b0;
      layer_done_reg <= 1'b0;

      if (state_reg == S_IDLE) begin
        start_sent_reg <= 1'b0;
        done_pend_reg  <= 1'b0;
        if (beat) begin
          para_reg    <= s.s_tdata[B_PARA-1:0];
          para_we_reg <= 1'b1;
          busy_reg    <= 1'b1;
        end
      end

      if (start_c) start_sent_reg <= 1'b1;

      if (((state_reg == S_WEI) || (state_reg == S_FTM)) && cmp_done && start_sent_reg) begin
        done_pend_reg <= 1'b1;
      end

      if ((state_reg == S_WAIT) && done_ok) begin
        layer_done_reg <= 1'b1;
        busy_reg       <= 1'b0;
        start_sent_reg <= 1'b0;
        done_pend_reg  <= 1'b0;
      end
    end
  end

  assign s.s_tready = rdy;
  assign di         = s.s_tdata;
  assign para       = para_reg;
  assign para_we    = para_we_reg;
  assign wb_clr     = (state_reg == S_CLR);
  assign fb_clr     = (state_reg == S_CLR);
  assign start      = start_c;
  assign busy       = busy_reg;
  assign layer_done = layer_done_reg;

endmodule

// File: tb/tb_conv_load_sched.sv
module tb_conv_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] para;
  logic        para_we;
  logic [63:0] di;
  logic        fb_we, wb_we, fb_clr, wb_clr;
  logic        fb_full, wb_full, fb_sufficient, wb_sufficient, cmp_done;
  logic        start, busy, layer_done;

  always #5 clk = ~clk;

  conv_load_sched_if #(.DW(64)) s_if ();

  conv_load_sched dut (
    .clk           (clk),
    .rst           (rst),
    .s             (s_if),
    .para          (para),
    .para_we       (para_we),
    .di            (di),
    .fb_we         (fb_we),
    .wb_we         (wb_we),
    .fb_clr        (fb_clr),
    .wb_clr        (wb_clr),
    .fb_full       (fb_full),
    .wb_full       (wb_full),
    .fb_sufficient (fb_sufficient),
    .wb_sufficient (wb_sufficient),
    .cmp_done      (cmp_done),
    .start         (start),
    .busy          (busy),
    .layer_done    (layer_done)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] tx_q [$];

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0;
  int para_we_cnt = 0, clr_cnt = 0, wb_cnt = 0, fb_cnt = 0;
  int start_cnt = 0, done_cnt = 0, viol_cnt = 0;
  int para_we_cyc = 0, clr_cyc = 0, last_wb_cyc = 0, last_fb_cyc = 0;
  int start_cyc = 0, done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic [63:0] last_para = '0;
  logic [63:0] wb_log [$];
  logic [63:0] fb_log [$];
  int          acc_cyc [$];
  int          fb_cyc_log [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (s_if.s_tvalid && s_if.s_tready) acc_cyc.push_back(cyc);
    if (para_we) begin para_we_cnt++; para_we_cyc = cyc; last_para = para; end
    if (fb_clr)  begin clr_cnt++; clr_cyc = cyc; end
    if (wb_we)   begin wb_cnt++; last_wb_cyc = cyc; wb_log.push_back(di); end
    if (fb_we)   begin fb_cnt++; last_fb_cyc = cyc; fb_log.push_back(di); fb_cyc_log.push_back(cyc); end
    if (start)   begin start_cnt++; start_cyc = cyc; end
    if (layer_done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if ((fb_we && wb_we) || (fb_we && fb_full) || (wb_we && wb_full) ||
        ((fb_clr || wb_clr) && (fb_we || wb_we)) || (fb_clr !== wb_clr) ||
        (di !== s_if.s_tdata))
      viol_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_layer(input logic [63:0] p, input int w, input int f);
    logic [31:0] w32, f32;
    w32 = w[31:0];
    f32 = f[31:0];
    tx_q.delete();
    tx_q.push_back(p);
    tx_q.push_back({w32, f32});
    for (int i = 0; i < w; i++) tx_q.push_back(64'hAA00_0000_0000_0000 | 64'(i));
    for (int i = 0; i < f; i++) tx_q.push_back(64'hFF00_0000_0000_0000 | 64'(i));
  endtask

  // Offers tx_q as a stream. bp=1 applies the back-pressure pattern;
  // cmp_at>=0 pulses cmp_done at that cycle index.
  task automatic drive(input int bp, input int cmp_at, input int max_cyc);
    int idx = 0;
    int c = 0;
    while (idx < tx_q.size() && c < max_cyc) begin
      @(posedge clk); #1;
      s_if.s_tvalid = 1'b1;
      s_if.s_tdata  = tx_q[idx];
      cmp_done      = (c == cmp_at);
      if (bp == 1) begin
        wb_full = (c >= 4 && c <= 6);
        fb_full = (c >= 10) && c[0];
      end
      @(negedge clk);
      if (bp == 1 && (wb_full || fb_full)) begin
        total++;
        if (s_if.s_tready !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_low c=%0d got=%b want=0", c, s_if.s_tready);
        end
      end
      if (bp == 1 && c >= 7 && c <= 9) begin
        total++;
        if (s_if.s_tready !== 1'b1) begin
          bad++;
          $display("FAIL bp_ready_high c=%0d got=%b want=1", c, s_if.s_tready);
        end
      end
      if (s_if.s_tready) idx++;
      c++;
    end
    total++;
    if (idx < tx_q.size()) begin
      bad++;
      $display("FAIL drive_timeout sent=%0d want=%0d", idx, tx_q.size());
    end
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b0;
    cmp_done = 1'b0;
    wb_full  = 1'b0;
    fb_full  = 1'b0;
  endtask

  task automatic pulse_cmp();
    @(posedge clk); #1 cmp_done = 1'b1;
    @(posedge clk); #1 cmp_done = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      @(negedge clk); #1;
      if (done_cnt > base) ok = 1'b1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int clr_b, done_b;
    @(negedge clk);
    total++;
    if ({s_if.s_tready, para_we, busy, start, layer_done, fb_clr, wb_clr, fb_we, wb_we} !== 9'b0 || para !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b para=%h want=0", {s_if.s_tready, para_we, busy, start, layer_done, fb_clr, wb_clr, fb_we, wb_we}, para);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_if.s_tready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle ready=%b busy=%b want ready=1 busy=0", s_if.s_tready, busy);
    end
    // Abort a layer while it sits in FTM
    wb_sufficient = 1'b0; fb_sufficient = 1'b0;
    load_layer(64'h0000_0000_0000_1234, 1, 8);
    repeat (5) void'(tx_q.pop_back());
    drive(0, -1, 50);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_busy got=%b want=1", busy);
    end
    clr_b = clr_cnt; done_b = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({s_if.s_tready, para_we, busy, start, layer_done, fb_clr, wb_clr, fb_we, wb_we} !== 9'b0 || para !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_ftm got=%b para=%h want=0", {s_if.s_tready, para_we, busy, start, layer_done, fb_clr, wb_clr, fb_we, wb_we}, para);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (s_if.s_tready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_back_idle ready=%b busy=%b want 1/0", s_if.s_tready, busy);
    end
    total++;
    if (clr_cnt != clr_b || done_cnt != done_b) begin
      bad++;
      $display("FAIL reset_no_side clr=%0d done=%0d want 0/0", clr_cnt - clr_b, done_cnt - done_b);
    end
  endtask

  task automatic test_nominal();
    int pw_b, clr_b, wb_b, fb_b, st_b, dn_b, acc_b;
    bit ok;
    logic [63:0] p;
    p = 64'h00C0_0301_0000_0055;
    pw_b = para_we_cnt; clr_b = clr_cnt; wb_b = wb_cnt; fb_b = fb_cnt;
    st_b = start_cnt; dn_b = done_cnt; acc_b = acc_cyc.size();
    wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    load_layer(p, 4, 10);
    drive(0, -1, 100);
    @(negedge clk); #1;
    total++;
    if (para_we_cnt - pw_b != 1 || last_para !== p) begin
      bad++;
      $display("FAIL nom_para n=%0d para=%h want 1 %h", para_we_cnt - pw_b, last_para, p);
    end
    total++;
    if (para_we_cyc != acc_cyc[acc_b] + 1) begin
      bad++;
      $display("FAIL nom_para_we_lat got=%0d want=%0d", para_we_cyc, acc_cyc[acc_b] + 1);
    end
    total++;
    if (clr_cnt - clr_b != 1) begin
      bad++;
      $display("FAIL nom_clr got=%0d want=1", clr_cnt - clr_b);
    end
    total++;
    if (wb_cnt - wb_b != 4 || fb_cnt - fb_b != 10) begin
      bad++;
      $display("FAIL nom_we wb=%0d fb=%0d want 4 10", wb_cnt - wb_b, fb_cnt - fb_b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wb_log[wb_b + i] !== (64'hAA00_0000_0000_0000 | 64'(i))) begin
          bad++;
          $display("FAIL nom_wdata i=%0d got=%h", i, wb_log[wb_b + i]);
        end
      end
      for (int i = 0; i < 10; i++) begin
        total++;
        if (fb_log[fb_b + i] !== (64'hFF00_0000_0000_0000 | 64'(i))) begin
          bad++;
          $display("FAIL nom_fdata i=%0d got=%h", i, fb_log[fb_b + i]);
        end
      end
    end
    total++;
    if (busy !== 1'b1 || done_cnt != dn_b) begin
      bad++;
      $display("FAIL nom_wait busy=%b done=%0d want 1 0", busy, done_cnt - dn_b);
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok || busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL nom_done ok=%0d busy=%b want 1 0", ok, busy_at_done);
    end
    total++;
    if (start_cnt - st_b != 1) begin
      bad++;
      $display("FAIL nom_start got=%0d want=1", start_cnt - st_b);
    end
  endtask

  task automatic test_back_pressure();
    int wb_b, fb_b, dn_b;
    bit ok;
    wb_b = wb_cnt; fb_b = fb_cnt; dn_b = done_cnt;
    wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    load_layer(64'h0000_0000_0000_0BB0, 4, 10);
    drive(1, -1, 200);
    @(negedge clk); #1;
    total++;
    if (wb_cnt - wb_b != 4 || fb_cnt - fb_b != 10) begin
      bad++;
      $display("FAIL bp_we wb=%0d fb=%0d want 4 10", wb_cnt - wb_b, fb_cnt - fb_b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wb_log[wb_b + i] !== (64'hAA00_0000_0000_0000 | 64'(i))) begin
          bad++;
          $display("FAIL bp_wdata i=%0d got=%h", i, wb_log[wb_b + i]);
        end
      end
      for (int i = 0; i < 10; i++) begin
        total++;
        if (fb_log[fb_b + i] !== (64'hFF00_0000_0000_0000 | 64'(i))) begin
          bad++;
          $display("FAIL bp_fdata i=%0d got=%h", i, fb_log[fb_b + i]);
        end
      end
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_done got=0 want=1");
    end
  endtask

  task automatic test_zero_counts();
    int wb_b, fb_b, st_b, dn_b, clr_b;
    bit ok;
    wb_b = wb_cnt; fb_b = fb_cnt; dn_b = done_cnt; clr_b = clr_cnt;
    wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    load_layer(64'h0000_0000_0000_0005, 0, 5);
    drive(0, -1, 50);
    @(negedge clk); #1;
    total++;
    if (wb_cnt - wb_b != 0 || fb_cnt - fb_b != 5 || clr_cnt - clr_b != 1) begin
      bad++;
      $display("FAIL zero_w wb=%0d fb=%0d clr=%0d want 0 5 1", wb_cnt - wb_b, fb_cnt - fb_b, clr_cnt - clr_b);
    end else begin
      total++;
      if (fb_cyc_log[fb_b] != clr_cyc + 1) begin
        bad++;
        $display("FAIL zero_w_first_fb got=%0d want=%0d", fb_cyc_log[fb_b], clr_cyc + 1);
      end
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL zero_w_done got=0 want=1");
    end
    // Both counts zero: straight to WAIT, start held off by sufficient
    wb_b = wb_cnt; fb_b = fb_cnt; dn_b = done_cnt; st_b = start_cnt;
    wb_sufficient = 1'b0; fb_sufficient = 1'b0;
    load_layer(64'h0000_0000_0000_0000, 0, 0);
    drive(0, -1, 50);
    pulse_cmp();
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (start_cnt != st_b || done_cnt != dn_b || busy !== 1'b1) begin
      bad++;
      $display("FAIL zero_both_hold start=%0d done=%0d busy=%b want 0 0 1", start_cnt - st_b, done_cnt - dn_b, busy);
    end
    @(posedge clk); #1 wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (start_cnt - st_b != 1 || wb_cnt != wb_b || fb_cnt != fb_b) begin
      bad++;
      $display("FAIL zero_both_start start=%0d wb=%0d fb=%0d want 1 0 0", start_cnt - st_b, wb_cnt - wb_b, fb_cnt - fb_b);
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL zero_both_done got=0 want=1");
    end
  endtask

  task automatic test_start_gating();
    int st_b, dn_b;
    bit ok;
    st_b = start_cnt; dn_b = done_cnt;
    wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    load_layer(64'h0000_0000_0000_0777, 3, 4);
    drive(0, -1, 50);
    @(negedge clk); #1;
    total++;
    if (start_cnt - st_b != 1 || start_cyc != last_wb_cyc + 1) begin
      bad++;
      $display("FAIL gate_start n=%0d cyc=%0d want 1 %0d", start_cnt - st_b, start_cyc, last_wb_cyc + 1);
    end
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (start_cnt - st_b != 1) begin
      bad++;
      $display("FAIL gate_once got=%0d want=1", start_cnt - st_b);
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL gate_done got=0 want=1");
    end
  endtask

  task automatic test_early_cmp_done();
    int dn_b;
    bit ok;
    logic [63:0] p2;
    dn_b = done_cnt;
    wb_sufficient = 1'b1; fb_sufficient = 1'b1;
    load_layer(64'h0000_0000_0000_0E01, 2, 6);
    drive(0, 7, 50);
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok || done_cyc != last_fb_cyc + 2) begin
      bad++;
      $display("FAIL early_done ok=%0d cyc=%0d want 1 %0d", ok, done_cyc, last_fb_cyc + 2);
    end
    total++;
    if (done_cnt - dn_b != 1) begin
      bad++;
      $display("FAIL early_done_cnt got=%0d want=1", done_cnt - dn_b);
    end
    p2 = 64'h1234_5678_9ABC_DEF0;
    dn_b = done_cnt;
    load_layer(p2, 1, 1);
    drive(0, -1, 50);
    @(negedge clk); #1;
    total++;
    if (last_para !== p2) begin
      bad++;
      $display("FAIL early_next_para got=%h want=%h", last_para, p2);
    end
    pulse_cmp();
    wait_done(dn_b, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL early_next_done got=0 want=1");
    end
  endtask

  initial begin
    rst = 1'b1;
    s_if.s_tvalid = 1'b0;
    s_if.s_tdata  = '0;
    fb_full = 1'b0; wb_full = 1'b0;
    fb_sufficient = 1'b0; wb_sufficient = 1'b0;
    cmp_done = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_nominal();
    test_back_pressure();
    test_zero_counts();
    test_start_gating();
    test_early_cmp_done();
    total++;
    if (viol_cnt != 0) begin
      bad++;
      $display("FAIL invariants got=%0d want=0", viol_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
